// File: rtl/cypher_nibble_feeder.sv
// Serializes a 32-bit word MSB-nibble first onto nibble/read for the cypher detector,
// with programmable setup (read low) and strobe (read high) lengths per nibble.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold, busy low
// SETUP  | new nibble presented, read low for SETUP_CYCLES
// STROBE | read high for STROBE_CYCLES, nibble stable
// DONE   | one-cycle done pulse, busy low
module cypher_nibble_feeder #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] data,
    output logic [3:0]  nibble,
    output logic        read,
    output logic        busy,
    output logic        done,
    output logic [2:0]  index
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] sreg_q, sreg_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        read_q, read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  index_q, index_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sreg_d   = sreg_q;
        nibble_d = nibble_q;
        read_d   = read_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        index_d  = index_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d   = data;
                    nibble_d = data[31:28];
                    index_d  = 3'd0;
                    busy_d   = 1'b1;
                    read_d   = 1'b0;
                    cnt_d    = 4'd0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    busy_d  = 1'b0;
                    index_d = 3'd0;
                    cnt_d   = 4'd0;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    read_d  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            STROBE: begin
                if (abort) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    busy_d  = 1'b0;
                    index_d = 3'd0;
                    cnt_d   = 4'd0;
                end else if (cnt_q == STROBE_LAST) begin
                    read_d = 1'b0;
                    cnt_d  = 4'd0;
                    if (index_q != 3'd7) begin
                        // nibble only moves once read has dropped
                        sreg_d   = {sreg_q[27:0], 4'h0};
                        nibble_d = sreg_q[27:24];
                        index_d  = index_q + 3'd1;
                        state_d  = SETUP;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sreg_q   <= 32'd0;
            nibble_q <= 4'd0;
            read_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            index_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sreg_q   <= sreg_d;
            nibble_q <= nibble_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            index_q  <= index_d;
        end
    end

    assign nibble = nibble_q;
    assign read   = read_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign index  = index_q;

endmodule

// File: tb/tb_cypher_nibble_feeder.sv
// Directed bench for cypher_nibble_feeder: default and (2,1) timing, abort,
// async reset mid-word, start while busy and back-to-back words.
module tb_cypher_nibble_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] data = 32'd0;
    logic [3:0]  nibble;
    logic        read, busy, done;
    logic [2:0]  index;

    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [31:0] data2 = 32'd0;
    logic [3:0]  nibble2;
    logic        read2, busy2, done2;
    logic [2:0]  index2;

    int total = 0;
    int bad = 0;

    cypher_nibble_feeder dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .data(data),
        .nibble(nibble), .read(read), .busy(busy), .done(done), .index(index)
    );

    cypher_nibble_feeder #(.SETUP_CYCLES(2), .STROBE_CYCLES(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .data(data2),
        .nibble(nibble2), .read(read2), .busy(busy2), .done(done2), .index(index2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] seq [8];
        logic [9:0] exp_v;
        int busy_cnt;
        int first_done;
        int second_done;
        logic seen;

        seq = '{4'h0, 4'h1, 4'h3, 4'h0, 4'h1, 4'h0, 4'h6, 4'h2};

        // start held high during reset must not be acted upon
        start = 1'b1;
        data  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({busy, done, read, index, nibble}), 32'd0);
        chk("rst_outs2", 32'({busy2, done2, read2, index2, nibble2}), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'({busy, done, read, index, nibble}), 32'd0);

        // default word, with a start/new-data pulse at index 2 and abort during DONE
        data  = 32'h01301062;
        start = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (busy) busy_cnt++;
            if (k < 32) begin
                exp_v = {1'b1, 1'b0, 1'((k % 4) != 0), 3'(k / 4), seq[k / 4]};
                chk($sformatf("word_k%0d", k), 32'({busy, done, read, index, nibble}), 32'(exp_v));
            end else if (k == 32) begin
                chk("done_pulse", 32'({busy, done, read}), 32'b010);
            end else begin
                chk("after_done", 32'({busy, done, read}), 32'b000);
            end
            if (k == 8) begin
                start = 1'b1;
                data  = 32'hFFFFFFFF;
            end
            if (k == 9) start = 1'b0;
            if (k == 32) abort = 1'b1;
            if (k == 33) abort = 1'b0;
        end
        chk("busy_len", 32'(busy_cnt), 32'd32);

        // SETUP_CYCLES=2, STROBE_CYCLES=1 instance
        data2  = 32'h89ABCDEF;
        start2 = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k == 0) start2 = 1'b0;
            if (busy2) busy_cnt++;
            if (k < 24) begin
                chk($sformatf("p_k%0d", k), 32'({read2, index2, nibble2}),
                    32'({1'((k % 3) == 2), 3'(k / 3), 4'(8 + k / 3)}));
            end else if (k == 24) begin
                chk("p_done", 32'({busy2, done2}), 32'b01);
            end
        end
        chk("p_busy_len", 32'(busy_cnt), 32'd24);

        // abort in the 2nd strobe cycle of index 4
        data  = 32'h12345678;
        start = 1'b1;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        chk("pre_abort", 32'({read, index}), 32'({1'b1, 3'd4}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outs", 32'({busy, done, read, index, nibble}), 32'({3'b000, 3'd0, 4'h5}));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || read || busy) seen = 1'b1;
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        // async reset during index 5
        data  = 32'hA5A5A5A5;
        start = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        chk("pre_reset", 32'({busy, read, index}), 32'({1'b1, 1'b1, 3'd5}));
        #2 reset = 1'b0;
        #1 chk("async_rst", 32'({busy, done, read, index, nibble}), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_hold", 32'({busy, done, read, index, nibble}), 32'd0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || read || busy) seen = 1'b1;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);

        // start held high: consecutive words
        data  = 32'h01301062;
        start = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
            end
        end
        start = 1'b0;
        chk("b2b_first", 32'(first_done), 32'd32);
        chk("b2b_gap", 32'(second_done - first_done), 32'd34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cypher_nibble_feeder.md
CYPHER_NIBBLE_FEEDER -- requirements
Module: cypher_nibble_feeder

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1, the number of cycles read is held low with a new nibble before the strobe (range 1..15).
REQ-002 SHALL have parameter STROBE_CYCLES, default 3, the number of cycles read is held high per nibble (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to serialize data; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of the current word.
REQ-007 SHALL have port data, input, 32, the word to serialize, MSB nibble first.
REQ-008 SHALL have port nibble, output, 4, the current nibble, driving the detector's in port.
REQ-009 SHALL have port read, output, 1, the nibble-valid strobe, driving the detector's read port.
REQ-010 SHALL have port busy, output, 1, high while a word is being serialized.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when all 8 nibbles have been strobed.
REQ-012 SHALL have port index, output, 3, the position of the nibble on nibble (0 = data[31:28], 7 = data[3:0]).

Function
REQ-013 SHALL register all outputs; no output is a combinational function of any input.
REQ-014 SHALL implement the states IDLE, SETUP, STROBE and DONE.
REQ-015 SHALL, in IDLE with start=1 at a rising edge, latch data into a 32-bit shift register and load nibble<=data[31:28], index<=0, busy<=1 and read<=0, and go to SETUP.
REQ-016 SHALL hold read=0 in SETUP for exactly SETUP_CYCLES cycles, then enter STROBE.
REQ-017 SHALL hold read=1 in STROBE for exactly STROBE_CYCLES cycles.
REQ-018 SHALL, at the end of STROBE with index<7, shift the register left by 4, load the next nibble, increment index, drive read<=0 and return to SETUP.
REQ-019 SHALL, at the end of STROBE with index=7, go to DONE with read<=0.
REQ-020 SHALL hold nibble constant from its load through the final STROBE cycle, so it is never changed while read=1.
REQ-021 SHALL, in DONE, assert done=1 and busy=0 for exactly one cycle, then enter IDLE.
REQ-022 SHALL make each word last exactly 8*(SETUP_CYCLES+STROBE_CYCLES) cycles with busy=1 (32 at the defaults), followed by 1 DONE cycle.
REQ-023 SHALL ignore start when the state is not IDLE; a changing data input has no effect after it is latched.
REQ-024 SHALL, when a start in IDLE coincides with the DONE→IDLE transition, accept start only from the IDLE cycle (one idle cycle minimum between words).
REQ-025 SHALL, on abort=1 in SETUP or STROBE, go to IDLE at the next edge with read=0, busy=0, done=0, index=0, and nibble unchanged.
REQ-026 SHALL give abort priority over every other transition; abort in IDLE or DONE has no effect, and DONE still pulses.
REQ-027 SHALL use internal cycle counters 4 bits wide that reset to 0 on every state entry, with no wrap-around within a state.

Reset
REQ-028 SHALL, while reset=0, immediately and asynchronously force state=IDLE, nibble=0, read=0, busy=0, done=0, index=0, counters=0 and the shift register to 0.
REQ-029 SHALL, when reset is asserted mid-word, discard that word; after release, wait in IDLE for a new start.
REQ-030 SHALL ignore start while reset=0 and take its first action on the first rising edge after reset=1.

Verification
REQ-031 SHALL be verified for a default-parameter word: data=32'h01301062 with start pulsed -> nibble sequence 0,1,3,0,1,0,6,2, each with 1 low and 3 high read cycles, done pulses 33 cycles after start, and the downstream cypher_detector with cypher=16'h2601 reports a match.
REQ-032 SHALL be verified for parameters: SETUP_CYCLES=2 and STROBE_CYCLES=1 -> read pattern 0,0,1 repeated 8 times, and busy high for 24 cycles.
REQ-033 SHALL be verified for abort: abort at the 2nd STROBE cycle of index=4 -> the next cycle read=0, busy=0, index=0, and no done pulse.
REQ-034 SHALL be verified for mid-word reset: reset=0 during index=5 -> outputs go to 0 without waiting for a clock edge, and no further read pulses occur until a new start.
REQ-035 SHALL be verified for start while busy: start re-pulsed with new data at index=2 -> ignored, and the original 8 nibbles complete unchanged.
REQ-036 SHALL be verified for back-to-back words: start held high continuously -> a second word begins in the IDLE cycle after done, and each done is separated by 34 cycles.
